// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed evaluator for one layer of 6-input truth-table neurons.
// One neuron per cycle; tables and fan-in maps are programmed while idle.
module lut_layer_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int FANIN       = 6,
    parameter int IN_WIDTH    = 32,
    localparam int NW         = $clog2(NUM_NEURONS),
    localparam int IW         = $clog2(IN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [NW+5:0]          cfg_addr,
    input  logic [IW-1:0]          cfg_wdata,
    output logic                   cfg_ready,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_data,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                                    state_q;
    logic                                      idle_q, out_valid_q, busy_q;
    logic [IN_WIDTH-1:0]                       vec_q;
    logic [NW-1:0]                             cnt_q;
    logic [NUM_NEURONS-1:0][63:0]              tbl_q;
    logic [NUM_NEURONS-1:0][FANIN-1:0][IW-1:0] map_q;
    logic [NUM_NEURONS-1:0]                    out_q;

    logic [NW-1:0] cfg_neuron;
    logic [5:0]    cfg_entry;
    logic [2:0]    cfg_slot;
    logic          neuron_ok, slot_ok, cfg_fire;
    logic [5:0]    eval_addr;
    logic          eval_bit;

    assign cfg_neuron = cfg_addr[NW+5:6];
    assign cfg_entry  = cfg_addr[5:0];
    assign cfg_slot   = cfg_addr[2:0];
    assign neuron_ok  = (int'(cfg_neuron) < NUM_NEURONS);
    assign slot_ok    = (cfg_slot < 3'(FANIN));
    assign cfg_fire   = cfg_we && (state_q == IDLE) && neuron_ok;

    // Gather the six table-address bits for the neuron under evaluation.
    always_comb begin
        eval_addr = '0;
        for (int k = 0; k < FANIN; k++)
            eval_addr[k] = vec_q[map_q[cnt_q][k]];
    end
    assign eval_bit = tbl_q[cnt_q][eval_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            vec_q       <= '0;
            cnt_q       <= '0;
            tbl_q       <= '0;
            map_q       <= '0;
            out_q       <= '0;
        end else begin
            if (cfg_fire && !cfg_sel)
                tbl_q[cfg_neuron][cfg_entry] <= cfg_wdata[0];
            if (cfg_fire && cfg_sel && slot_ok)
                map_q[cfg_neuron][cfg_slot] <= cfg_wdata;
            case (state_q)
                IDLE: if (in_valid) begin
                    vec_q   <= in_data;
                    cnt_q   <= '0;
                    state_q <= EVAL;
                    idle_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                EVAL: begin
                    out_q[cnt_q] <= eval_bit;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == NW'(NUM_NEURONS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    idle_q      <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    idle_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = idle_q;
    assign cfg_ready = idle_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_q;

endmodule
